uart_transmitter_buffered: RTL and testbench
============================================

// Module: uart_transmitter_buffered
// PURPOSE
//   Transmit side of the board UART link: accepts bytes from the CPU over a
//   ready/valid port, buffers them in a small FIFO and serialises each as an
//   8N1 frame on serial_out. Its output drives the FPGA_SERIAL_TX IOB register.
//   It complements the RX sampling path and lets the CPU queue bytes without
//   waiting for each frame to finish.
// PARAMETERS
//   CLOCK_FREQ  50_000_000  clk frequency in Hz
//   BAUD_RATE   115_200     line rate; SYMBOL_CYCLES = CLOCK_FREQ / BAUD_RATE (integer floor, 434 by default)
//   FIFO_DEPTH  8           buffered bytes, power of two >= 2
// PORTS
//   clk            in   1   single clock, all logic on posedge
//   rst            in   1   asynchronous, active-high reset
//   data_in        in   8   byte to transmit
//   data_in_valid  in   1   data_in is valid this cycle
//   data_in_ready  out  1   FIFO can accept a byte (= !full)
//   serial_out     out  1   UART line, idle high, registered
//   tx_busy        out  1   FIFO non-empty or frame in progress
//   fifo_count     out  $clog2(FIFO_DEPTH)+1  bytes waiting in FIFO
// BEHAVIOUR
//   Reset (async, immediate): serial_out=1, FSM=IDLE, FIFO flushed,
//     fifo_count=0, tx_busy=0, data_in_ready=1. Reset mid-frame aborts the
//     frame and forces the line high at once; no partial frame resumes.
//   Push: byte written on a posedge with data_in_valid && data_in_ready.
//     Full FIFO => data_in_ready=0 even if a pop occurs the same cycle.
//     data_in ignored when valid=0. No pop occurs when FIFO is empty.
//   Simultaneous push+pop (non-full): fifo_count unchanged, both take effect.
//   Pointers are $clog2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH.
//   FSM states: IDLE -> START -> DATA -> STOP -> (START | IDLE).
//     IDLE: serial_out=1; if FIFO non-empty, pop head into shift reg, go START.
//     START: serial_out=0 for SYMBOL_CYCLES cycles.
//     DATA: 8 bits LSB first, each held SYMBOL_CYCLES cycles (bit counter 0..7).
//     STOP: serial_out=1 for SYMBOL_CYCLES; on last cycle, if FIFO non-empty,
//       pop and go straight to START (no idle gap), else go IDLE.
//   Latency: byte pushed into an empty FIFO with idle FSM at edge k => pop at
//     edge k+1; serial_out falls at edge k+1. Frame = 10*SYMBOL_CYCLES cycles.
//   Baud counter counts 0..SYMBOL_CYCLES-1, cleared on every state entry.
//   tx_busy = (FSM != IDLE) || (fifo_count != 0); falls on the edge that ends
//     the final stop bit.
//   serial_out is a flop output only; no combinational glitches.
// TESTING
//   1 rst pulse at cycle 1000 of a frame -> serial_out=1 immediately,
//     fifo_count=0, tx_busy=0, data_in_ready=1; no further line activity.
//   2 push 0xA5 at edge k -> line low from k+1 for 434 cycles, then bits
//     1,0,1,0,0,1,0,1 (434 each), stop high 434; tx_busy low at k+1+4340.
//   3 push 0x00,0xFF,0x55 back-to-back -> three contiguous 4340-cycle frames,
//     no idle cycle between stop and next start; decoded bytes match.
//   4 hold valid high with 10 distinct bytes -> 9 accepted (1 in shifter,
//     8 queued), data_in_ready=0, fifo_count=8; 10th accepted the cycle
//     after second pop; all 10 bytes appear on the line in order.
//   5 valid toggled with data changing while ready=0 or valid=0 -> no extra
//     bytes transmitted, fifo_count unchanged.
//   6 CLOCK_FREQ=1000, BAUD_RATE=300 -> SYMBOL_CYCLES=3, frame 30 cycles.

Source files
------------

// File: rtl/uart_transmitter_buffered.sv
// Buffered 8N1 UART transmitter: ready/valid byte intake, FIFO, and a serialiser
// that chains frames back-to-back while bytes are waiting.
module uart_transmitter_buffered #(
  parameter int unsigned CLOCK_FREQ = 50_000_000,
  parameter int unsigned BAUD_RATE  = 115_200,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    data_in,
  input  logic                          data_in_valid,
  output logic                          data_in_ready,
  output logic                          serial_out,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned SYMBOL_CYCLES = CLOCK_FREQ / BAUD_RATE;
  localparam int unsigned CNT_W         = (SYMBOL_CYCLES > 1) ? $clog2(SYMBOL_CYCLES) : 1;
  localparam int unsigned PTR_W         = $clog2(FIFO_DEPTH);
  localparam int unsigned COUNT_W       = PTR_W + 1;
  localparam logic [CNT_W-1:0]   LAST_BAUD = CNT_W'(SYMBOL_CYCLES - 1);
  localparam logic [COUNT_W-1:0] FULL_CNT  = COUNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   baud_cnt;
  logic [2:0]         bit_cnt, bit_cnt_d;
  logic [7:0]         shift_reg;
  logic [7:0]         mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [COUNT_W-1:0] count_d;
  logic               push_c, pop_c, symbol_end_c, fifo_empty_c, serial_d;

  assign push_c       = data_in_valid && data_in_ready;
  assign fifo_empty_c = (fifo_count == '0);
  assign symbol_end_c = (baud_cnt == LAST_BAUD);
  assign count_d      = fifo_count + COUNT_W'(push_c) - COUNT_W'(pop_c);

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (!fifo_empty_c) state_d = S_START;
      S_START: if (symbol_end_c) state_d = S_DATA;
      S_DATA:  if (symbol_end_c && bit_cnt == 3'd7) state_d = S_STOP;
      S_STOP:  if (symbol_end_c) state_d = fifo_empty_c ? S_IDLE : S_START;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: pop request, next bit index and the next line level
  always_comb begin
    pop_c     = 1'b0;
    bit_cnt_d = '0;
    serial_d  = 1'b1;
    if (!fifo_empty_c && (state_q == S_IDLE || (state_q == S_STOP && symbol_end_c)))
      pop_c = 1'b1;
    if (state_q == S_DATA)
      bit_cnt_d = symbol_end_c ? bit_cnt + 3'd1 : bit_cnt;
    case (state_d)
      S_START: serial_d = 1'b0;
      S_DATA:  serial_d = shift_reg[bit_cnt_d];
      default: serial_d = 1'b1;
    endcase
  end

  // Baud/bit counters, shifter load and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      baud_cnt      <= '0;
      bit_cnt       <= '0;
      shift_reg     <= '0;
      serial_out    <= 1'b1;
      tx_busy       <= 1'b0;
      data_in_ready <= 1'b1;
    end else begin
      if (state_d != state_q || symbol_end_c || state_q == S_IDLE) baud_cnt <= '0;
      else                                                           baud_cnt <= baud_cnt + CNT_W'(1);
      bit_cnt       <= bit_cnt_d;
      if (pop_c) shift_reg <= mem[rd_ptr];
      serial_out    <= serial_d;
      tx_busy       <= (state_d != S_IDLE) || (count_d != '0);
      data_in_ready <= (count_d != FULL_CNT);
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
      fifo_count <= count_d;
    end
  end

  // FIFO storage (contents need no reset; occupancy gates every read)
  always_ff @(posedge clk) begin
    if (push_c) mem[wr_ptr] <= data_in;
  end

endmodule

// File: tb/tb_uart_transmitter_buffered.sv
// Bench for uart_transmitter_buffered: a default-rate instance (434 cycles/bit)
// and a slow instance (3 cycles/bit), with a line decoder per instance that
// checks every frame against a queue of expected bytes.
module tb_uart_transmitter_buffered;

  localparam int SC_A    = 434;
  localparam int SC_B    = 3;
  localparam int FRAME_A = 10 * SC_A;
  localparam int FRAME_B = 10 * SC_B;

  logic       clk;
  logic       rst;
  logic [7:0] data_a, data_b;
  logic       valid_a, valid_b, ready_a, ready_b, so_a, so_b, busy_a, busy_b;
  logic [3:0] count_a, count_b;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [7:0] exp_a[$];
  logic [7:0] exp_b[$];
  int starts_a[$];
  int starts_b[$];

  uart_transmitter_buffered dut_a (
    .clk(clk), .rst(rst), .data_in(data_a), .data_in_valid(valid_a),
    .data_in_ready(ready_a), .serial_out(so_a), .tx_busy(busy_a), .fifo_count(count_a)
  );

  uart_transmitter_buffered #(.CLOCK_FREQ(1000), .BAUD_RATE(300), .FIFO_DEPTH(8)) dut_b (
    .clk(clk), .rst(rst), .data_in(data_b), .data_in_valid(valid_b),
    .data_in_ready(ready_b), .serial_out(so_b), .tx_busy(busy_b), .fifo_count(count_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Receive one frame whose first start-bit sample was just taken
  task automatic rx_frame(input bit which, input int sc, output logic [7:0] d,
                          output bit ok, output bit aborted);
    logic first, line;
    ok = 1'b1; aborted = 1'b0; d = '0; first = 1'b0;
    for (int s = 0; s < 10; s++) begin
      for (int c = 0; c < sc; c++) begin
        if (s != 0 || c != 0) @(negedge clk);
        if (rst) begin aborted = 1'b1; return; end
        line = which ? so_b : so_a;
        if (c == 0) first = line;
        else if (line !== first) ok = 1'b0;
        if (c == sc - 1) begin
          if (s == 0 && first !== 1'b0) ok = 1'b0;
          else if (s == 9 && first !== 1'b1) ok = 1'b0;
          else if (s >= 1 && s <= 8) d[s-1] = first;
        end
      end
    end
  endtask

  // Line decoder and scoreboard for one instance
  task automatic monitor(input bit which);
    logic prev, line;
    logic [7:0] d, e;
    bit ok, ab;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      line = which ? so_b : so_a;
      if (rst) prev = 1'b1;
      else if (prev === 1'b1 && line === 1'b0) begin
        if (which) starts_b.push_back(cyc); else starts_a.push_back(cyc);
        rx_frame(which, which ? SC_B : SC_A, d, ok, ab);
        prev = 1'b1;
        if (!ab) begin
          checks++;
          if ((which ? exp_b.size() : exp_a.size()) == 0) begin
            errors++; $display("FAIL rx_unexpected_%0d: got byte %02h at cycle %0d, no byte expected", which, d, cyc);
          end else begin
            e = which ? exp_b.pop_front() : exp_a.pop_front();
            if (!ok || d !== e) begin
              errors++; $display("FAIL rx_byte_%0d: got %02h framing_ok=%0d, expected %02h framing_ok=1", which, d, ok, e);
            end
          end
        end
      end else prev = line;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; valid_a = 1'b0; valid_b = 1'b0; data_a = '0; data_b = '0;
    repeat (3) @(negedge clk);
    checks++; if (so_a !== 1'b1) begin errors++; $display("FAIL reset_serial_a: got %b expected 1", so_a); end
    checks++; if (ready_a !== 1'b1) begin errors++; $display("FAIL reset_ready_a: got %b expected 1", ready_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy_a: got %b expected 0", busy_a); end
    checks++; if (count_a !== 4'd0) begin errors++; $display("FAIL reset_count_a: got %0d expected 0", count_a); end
    checks++; if (so_b !== 1'b1 || ready_b !== 1'b1) begin errors++; $display("FAIL reset_b: got serial %b ready %b expected 1 1", so_b, ready_b); end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (so_a !== 1'b1 || busy_a !== 1'b0) begin errors++; $display("FAIL idle_after_reset: got serial %b busy %b expected 1 0", so_a, busy_a); end
  endtask

  task automatic test_single_frame;
    int k, n0, got;
    n0 = starts_a.size();
    data_a = 8'hA5; valid_a = 1'b1; exp_a.push_back(8'hA5); k = cyc + 1;
    @(negedge clk); valid_a = 1'b0; data_a = 8'h5A;
    checks++; if (count_a !== 4'd1 || busy_a !== 1'b1 || so_a !== 1'b1) begin errors++; $display("FAIL push_edge: got count %0d busy %b serial %b expected 1 1 1", count_a, busy_a, so_a); end
    @(negedge clk);
    checks++; if (so_a !== 1'b0 || count_a !== 4'd0) begin errors++; $display("FAIL pop_edge: got serial %b count %0d expected 0 0", so_a, count_a); end
    while (cyc < k + FRAME_A) @(negedge clk);
    checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL busy_last_stop: got %b expected 1", busy_a); end
    @(negedge clk);
    checks++; if (busy_a !== 1'b0 || so_a !== 1'b1) begin errors++; $display("FAIL busy_fall: got busy %b serial %b expected 0 1", busy_a, so_a); end
    got = (starts_a.size() > n0) ? starts_a[n0] : -1;
    checks++; if (got != k + 1) begin errors++; $display("FAIL single_start_cycle: got %0d expected %0d", got, k + 1); end
    repeat (3) @(negedge clk);
    checks++; if (exp_a.size() != 0) begin errors++; $display("FAIL single_missing: got %0d pending expected 0", exp_a.size()); end
  endtask

  task automatic test_back_to_back;
    int k, n0, got;
    logic [7:0] b [3];
    b[0] = 8'h00; b[1] = 8'hFF; b[2] = 8'h55;
    n0 = starts_a.size(); k = cyc + 1;
    for (int j = 0; j < 3; j++) begin
      data_a = b[j]; valid_a = 1'b1; exp_a.push_back(b[j]);
      @(negedge clk);
    end
    valid_a = 1'b0;
    while (cyc < k + 3 * FRAME_A) @(negedge clk);
    checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL b2b_busy_last: got %b expected 1", busy_a); end
    repeat (3) @(negedge clk);
    for (int j = 0; j < 3; j++) begin
      got = (starts_a.size() > n0 + j) ? starts_a[n0 + j] : -1;
      checks++; if (got != k + 1 + j * FRAME_A) begin errors++; $display("FAIL b2b_start_%0d: got %0d expected %0d", j, got, k + 1 + j * FRAME_A); end
    end
    checks++; if (exp_a.size() != 0 || busy_a !== 1'b0) begin errors++; $display("FAIL b2b_drain: got pending %0d busy %b expected 0 0", exp_a.size(), busy_a); end
  endtask

  task automatic test_reset_midframe;
    int k, n0, low;
    data_a = 8'h3C; valid_a = 1'b1; exp_a.push_back(8'h3C); k = cyc + 1;
    @(negedge clk); data_a = 8'h81; exp_a.push_back(8'h81);
    @(negedge clk); valid_a = 1'b0;
    while (cyc < k + 1 + 1000) @(negedge clk);
    checks++; if (so_a !== 1'b0 || count_a !== 4'd1) begin errors++; $display("FAIL midframe_pre: got serial %b count %0d expected 0 1", so_a, count_a); end
    #2 rst = 1'b1;
    #1;
    checks++; if (so_a !== 1'b1) begin errors++; $display("FAIL rst_serial_now: got %b expected 1", so_a); end
    checks++; if (count_a !== 4'd0 || busy_a !== 1'b0 || ready_a !== 1'b1) begin errors++; $display("FAIL rst_flags_now: got count %0d busy %b ready %b expected 0 0 1", count_a, busy_a, ready_a); end
    exp_a.delete();
    n0 = starts_a.size();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    low = 0;
    repeat (1500) begin
      @(negedge clk);
      if (so_a !== 1'b1 || busy_a !== 1'b0) low++;
    end
    checks++; if (low != 0 || starts_a.size() != n0) begin errors++; $display("FAIL post_reset_quiet: got %0d active cycles %0d frames expected 0 0", low, starts_a.size() - n0); end
  endtask

  task automatic test_small_baud;
    int k, n0, got;
    n0 = starts_b.size();
    data_b = 8'h96; valid_b = 1'b1; exp_b.push_back(8'h96); k = cyc + 1;
    @(negedge clk); valid_b = 1'b0;
    while (cyc < k + FRAME_B) @(negedge clk);
    checks++; if (busy_b !== 1'b1) begin errors++; $display("FAIL small_busy_last: got %b expected 1", busy_b); end
    @(negedge clk);
    checks++; if (busy_b !== 1'b0) begin errors++; $display("FAIL small_busy_fall: got %b expected 0", busy_b); end
    got = (starts_b.size() > n0) ? starts_b[n0] : -1;
    checks++; if (got != k + 1) begin errors++; $display("FAIL small_start_cycle: got %0d expected %0d", got, k + 1); end
    repeat (3) @(negedge clk);
    checks++; if (exp_b.size() != 0) begin errors++; $display("FAIL small_missing: got %0d pending expected 0", exp_b.size()); end
  endtask

  task automatic test_fill;
    int i, budget, n0, bad, got;
    int acc_cyc [10];
    logic [7:0] bytes [10];
    bit acc, seen9;
    for (int j = 0; j < 10; j++) begin bytes[j] = 8'(j * 37 + 5); acc_cyc[j] = 0; end
    n0 = starts_b.size(); i = 0; budget = 0; seen9 = 1'b0;
    data_b = bytes[0]; valid_b = 1'b1;
    while (i < 10 && budget < 300) begin
      acc = ready_b;
      @(negedge clk); budget++;
      if (acc) begin
        exp_b.push_back(bytes[i]); acc_cyc[i] = cyc; i++;
        if (i < 10) data_b = bytes[i];
      end
      if (i == 9 && !seen9) begin
        seen9 = 1'b1;
        checks++; if (count_b !== 4'd8 || ready_b !== 1'b0) begin errors++; $display("FAIL fill_full: got count %0d ready %b expected 8 0", count_b, ready_b); end
      end
    end
    valid_b = 1'b0;
    checks++; if (i != 10) begin errors++; $display("FAIL fill_timeout: got %0d accepted expected 10", i); end
    else begin
      checks++; if (acc_cyc[8] - acc_cyc[0] != 8) begin errors++; $display("FAIL fill_burst: got span %0d expected 8", acc_cyc[8] - acc_cyc[0]); end
      checks++; if (acc_cyc[9] != acc_cyc[0] + 2 + FRAME_B) begin errors++; $display("FAIL fill_tenth: got cycle %0d expected %0d", acc_cyc[9], acc_cyc[0] + 2 + FRAME_B); end
    end
    while (cyc < acc_cyc[0] + 1 + 10 * FRAME_B + 3) @(negedge clk);
    bad = 0;
    for (int j = 0; j < 10; j++) begin
      got = (starts_b.size() > n0 + j) ? starts_b[n0 + j] : -1;
      if (got != acc_cyc[0] + 1 + j * FRAME_B) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL fill_contiguous: got %0d misplaced frames expected 0", bad); end
    checks++; if (exp_b.size() != 0 || busy_b !== 1'b0) begin errors++; $display("FAIL fill_drain: got pending %0d busy %b expected 0 0", exp_b.size(), busy_b); end
  endtask

  task automatic test_ignore;
    int n0, bad;
    n0 = starts_b.size();
    repeat (20) begin data_b = 8'($urandom); valid_b = 1'b0; @(negedge clk); end
    checks++; if (count_b !== 4'd0 || busy_b !== 1'b0) begin errors++; $display("FAIL invalid_ignored: got count %0d busy %b expected 0 0", count_b, busy_b); end
    for (int j = 0; j < 9; j++) begin
      data_b = 8'(8'h10 + j); valid_b = 1'b1; exp_b.push_back(8'(8'h10 + j));
      @(negedge clk);
    end
    valid_b = 1'b0; bad = 0;
    repeat (20) begin
      if (ready_b === 1'b0) begin valid_b = 1'($urandom); data_b = 8'($urandom); end
      else valid_b = 1'b0;
      @(negedge clk);
      if (count_b !== 4'd8) bad++;
    end
    valid_b = 1'b0;
    checks++; if (bad != 0) begin errors++; $display("FAIL full_ignored: got %0d cycles with count not 8, expected 0", bad); end
    repeat (9 * FRAME_B + 10) @(negedge clk);
    checks++; if (starts_b.size() != n0 + 9 || exp_b.size() != 0) begin errors++; $display("FAIL ignore_frames: got %0d frames %0d pending expected 9 0", starts_b.size() - n0, exp_b.size()); end
  endtask

  initial begin
    rst = 1'b1;
    fork
      monitor(1'b0);
      monitor(1'b1);
    join_none
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_reset_midframe();
    test_small_baud();
    test_fill();
    test_ignore();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
